// File: rtl/a2d_spi_serf.sv
// ---------------------------------------------------------------------------
// a2d_spi_serf
//   SPI responder modelling an 8-channel, 12-bit A2D converter. Each 16-bit
//   frame shifts in a channel-select command (bits [13:11]) and shifts out
//   the conversion of the channel selected by the previous good frame.
//   SCLK/SS_n/MOSI are oversampled on clk; nothing is clocked by SCLK.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   SS_n     in   serf select, active low, async to clk
//   SCLK     in   serial clock, idles high
//   MOSI     in   serial data in, MSB first
//   MISO     out  serial data out, MSB first (0 while deselected)
//   ch_data  in   packed conversions, channel n = ch_data[12n+11:12n]
//   ch_sel   out  channel latched by last good command frame
//   cmd_vld  out  one-clk pulse per accepted 16-bit frame
//   frm_err  out  one-clk pulse when a frame ends with bit count != 16
// ---------------------------------------------------------------------------
module a2d_spi_serf #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   SS_n,
    input  logic                   SCLK,
    input  logic                   MOSI,
    output logic                   MISO,
    input  logic [8*DATA_BITS-1:0] ch_data,
    output logic [2:0]             ch_sel,
    output logic                   cmd_vld,
    output logic                   frm_err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_ss_s1, r_ss_s2, r_ss_s3;
    logic                  r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic                  r_mosi_s1, r_mosi_s2;
    logic [FRAME_BITS-1:0] r_tx_shft, w_tx_nxt;
    logic [FRAME_BITS-1:0] r_rx_shft, w_rx_nxt;
    logic [4:0]            r_bit_cnt, w_cnt_nxt;
    logic                  r_first_fall, w_ff_nxt;
    logic [2:0]            r_ch_sel, w_sel_nxt;
    logic                  r_cmd_vld, w_vld_nxt;
    logic                  r_frm_err, w_err_nxt;
    logic [DATA_BITS-1:0]  w_ch_word;
    logic                  w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

    assign w_sclk_rise =  r_sclk_s2 & ~r_sclk_s3;
    assign w_sclk_fall = ~r_sclk_s2 &  r_sclk_s3;
    assign w_ss_fall   = ~r_ss_s2   &  r_ss_s3;
    assign w_ss_rise   =  r_ss_s2   & ~r_ss_s3;

    always_comb begin
        w_ch_word = '0;
        for (int unsigned i = 0; i < 8; i++)
            if (r_ch_sel == 3'(i))
                w_ch_word = ch_data[i*DATA_BITS +: DATA_BITS];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx_shft;
        w_rx_nxt    = r_rx_shft;
        w_cnt_nxt   = r_bit_cnt;
        w_ff_nxt    = r_first_fall;
        w_sel_nxt   = r_ch_sel;
        w_vld_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_tx_nxt    = {{(FRAME_BITS-DATA_BITS){1'b0}}, w_ch_word};
                    w_cnt_nxt   = '0;
                    w_ff_nxt    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_sclk_rise) begin
                    w_rx_nxt = {r_rx_shft[FRAME_BITS-2:0], r_mosi_s2};
                    if (r_bit_cnt != 5'd31)
                        w_cnt_nxt = r_bit_cnt + 5'd1;
                end
                // First SCLK fall only starts the clock; the MSB is already on MISO.
                if (w_sclk_fall) begin
                    if (r_first_fall)
                        w_ff_nxt = 1'b0;
                    else
                        w_tx_nxt = {r_tx_shft[FRAME_BITS-2:0], 1'b0};
                end
                // Uses the post-shift values so a coincident last rise is counted.
                if (w_ss_rise) begin
                    w_state_nxt = IDLE;
                    if (w_cnt_nxt == 5'(FRAME_BITS)) begin
                        w_sel_nxt = w_rx_nxt[13:11];
                        w_vld_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ss_s1      <= 1'b1;
            r_ss_s2      <= 1'b1;
            r_ss_s3      <= 1'b1;
            r_sclk_s1    <= 1'b1;
            r_sclk_s2    <= 1'b1;
            r_sclk_s3    <= 1'b1;
            r_mosi_s1    <= 1'b0;
            r_mosi_s2    <= 1'b0;
            r_tx_shft    <= '0;
            r_rx_shft    <= '0;
            r_bit_cnt    <= '0;
            r_first_fall <= 1'b0;
            r_ch_sel     <= '0;
            r_cmd_vld    <= 1'b0;
            r_frm_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ss_s1      <= SS_n;
            r_ss_s2      <= r_ss_s1;
            r_ss_s3      <= r_ss_s2;
            r_sclk_s1    <= SCLK;
            r_sclk_s2    <= r_sclk_s1;
            r_sclk_s3    <= r_sclk_s2;
            r_mosi_s1    <= MOSI;
            r_mosi_s2    <= r_mosi_s1;
            r_tx_shft    <= w_tx_nxt;
            r_rx_shft    <= w_rx_nxt;
            r_bit_cnt    <= w_cnt_nxt;
            r_first_fall <= w_ff_nxt;
            r_ch_sel     <= w_sel_nxt;
            r_cmd_vld    <= w_vld_nxt;
            r_frm_err    <= w_err_nxt;
        end
    end

    assign MISO    = r_tx_shft[FRAME_BITS-1] & ~r_ss_s2;
    assign ch_sel  = r_ch_sel;
    assign cmd_vld = r_cmd_vld;
    assign frm_err = r_frm_err;

endmodule

// File: tb/tb_a2d_spi_serf.sv
// ---------------------------------------------------------------------------
// tb_a2d_spi_serf
//   Directed and randomized SPI frames against a2d_spi_serf. The reference
//   model tracks the selected channel and predicts each frame's response as
//   {4'h0, ch_data[sel]} captured at frame start.
// ---------------------------------------------------------------------------
module tb_a2d_spi_serf;

    logic        clk;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [95:0] ch_data;
    logic [2:0]  ch_sel;
    logic        cmd_vld;
    logic        frm_err;

    int checks = 0;
    int errors = 0;
    int n_vld  = 0;
    int n_err  = 0;
    logic [2:0] model_sel;

    a2d_spi_serf #(.FRAME_BITS(16), .DATA_BITS(12)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .ch_data (ch_data),
        .ch_sel  (ch_sel),
        .cmd_vld (cmd_vld),
        .frm_err (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_vld === 1'b1) n_vld++;
        if (frm_err === 1'b1) n_err++;
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] mk_cmd(input logic [2:0] sel);
        logic [15:0] c;
        c = 16'($urandom);
        c[13:11] = sel;
        return c;
    endfunction

    function automatic logic [15:0] resp(input logic [95:0] d, input logic [2:0] sel);
        return {4'h0, d[sel*12 +: 12]};
    endfunction

    // Drives one frame of nr SCLK cycles; MISO is sampled just before each rise.
    task automatic frame(input logic [15:0] cmd, input int nr, input int chg_fall,
                         input logic [95:0] chg_data, input bit merge,
                         output logic [15:0] cap);
        cap  = '0;
        SS_n = 1'b0;
        wclk(5);
        for (int i = 0; i < nr; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            if (i + 1 == chg_fall) ch_data = chg_data;
            wclk(5);
            if (i < 16) cap[15-i] = MISO;
            SCLK = 1'b1;
            if (merge && i == nr - 1) SS_n = 1'b1;
            else wclk(5);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
    endtask

    task automatic run(input string tag, input logic [15:0] cmd, input int nr,
                       input int chg_fall, input logic [95:0] chg_data, input bit merge);
        logic [15:0] exp_w, cap;
        int v0, e0, k;
        bit full;
        v0    = n_vld;
        e0    = n_err;
        exp_w = resp(ch_data, model_sel);
        frame(cmd, nr, chg_fall, chg_data, merge, cap);
        wclk(8);
        k    = (nr < 16) ? nr : 16;
        full = (nr == 16);
        if (k > 0) begin
            checks++;
            assert ((cap >> (16 - k)) === (exp_w >> (16 - k))) else begin
                errors++;
                $error("FAIL %s miso obs=%h exp=%h bits=%0d", tag, cap, exp_w, k);
            end
        end
        checks++;
        assert ((n_vld - v0) === (full ? 1 : 0)) else begin
            errors++;
            $error("FAIL %s cmd_vld pulses obs=%0d exp=%0d", tag, n_vld - v0, full ? 1 : 0);
        end
        checks++;
        assert ((n_err - e0) === (full ? 0 : 1)) else begin
            errors++;
            $error("FAIL %s frm_err pulses obs=%0d exp=%0d", tag, n_err - e0, full ? 0 : 1);
        end
        if (full) model_sel = cmd[13:11];
        checks++;
        assert (ch_sel === model_sel) else begin
            errors++;
            $error("FAIL %s ch_sel obs=%0d exp=%0d", tag, ch_sel, model_sel);
        end
        checks++;
        assert (MISO === 1'b0) else begin
            errors++;
            $error("FAIL %s idle_miso obs=%b exp=0", tag, MISO);
        end
    endtask

    initial begin
        logic [15:0] cap_a, cap_b, exp_a, exp_b, cmd_a, cmd_b;
        logic [95:0] nd;
        int v0, nr;

        rst_n     = 1'b0;
        SS_n      = 1'b1;
        SCLK      = 1'b1;
        MOSI      = 1'b0;
        model_sel = '0;
        ch_data   = {$urandom, $urandom, $urandom};
        ch_data[11:0] = 12'hABC;
        wclk(3);
        checks++;
        assert (ch_sel === 3'd0 && MISO === 1'b0 && cmd_vld === 1'b0 && frm_err === 1'b0) else begin
            errors++;
            $error("FAIL reset_outs obs=%0d/%b/%b/%b exp=0/0/0/0", ch_sel, MISO, cmd_vld, frm_err);
        end
        rst_n = 1'b1;
        wclk(5);
        checks++;
        assert (ch_sel === 3'd0 && MISO === 1'b0) else begin
            errors++;
            $error("FAIL post_reset obs=%0d/%b exp=0/0", ch_sel, MISO);
        end

        // Channel 0 read right after reset.
        run("ch0", 16'h0000, 16, 0, '0, 1'b0);

        // Two-frame read of channel 5.
        ch_data[71:60] = 12'h5A3;
        run("sel5", 16'h2800, 16, 0, '0, 1'b0);
        run("read5", 16'h0001, 16, 0, '0, 1'b0);

        // Round robin 0,4,5,6,0.
        ch_data[11:0]  = 12'h111;
        ch_data[59:48] = 12'h444;
        ch_data[71:60] = 12'h555;
        ch_data[83:72] = 12'h666;
        run("rr0", mk_cmd(3'd0), 16, 0, '0, 1'b0);
        run("rr4", mk_cmd(3'd4), 16, 0, '0, 1'b0);
        run("rr5", mk_cmd(3'd5), 16, 0, '0, 1'b0);
        run("rr6", mk_cmd(3'd6), 16, 0, '0, 1'b0);
        run("rr0b", mk_cmd(3'd0), 16, 0, '0, 1'b0);
        run("rrend", mk_cmd(3'd1), 16, 0, '0, 1'b0);

        // Snapshot: ch3 changes after the 4th SCLK fall of the response frame.
        ch_data[47:36] = 12'h123;
        run("snap_sel", mk_cmd(3'd3), 16, 0, '0, 1'b0);
        nd = ch_data;
        nd[47:36] = 12'hFFF;
        run("snap", mk_cmd(3'd2), 16, 4, nd, 1'b0);

        // Short frame, then a normal one.
        run("short9", mk_cmd(3'd7), 9, 0, '0, 1'b0);
        run("after_short", mk_cmd(3'd5), 16, 0, '0, 1'b0);

        // Last SCLK rise coincident with SS_n rise.
        run("merge", mk_cmd(3'd6), 16, 0, '0, 1'b1);
        run("merge_rd", mk_cmd(3'd1), 16, 0, '0, 1'b0);

        // Back-to-back frames with SS_n high for only 2 clk.
        cmd_a = mk_cmd(3'd4);
        cmd_b = mk_cmd(3'd2);
        v0    = n_vld;
        exp_a = resp(ch_data, model_sel);
        exp_b = resp(ch_data, cmd_a[13:11]);
        frame(cmd_a, 16, 0, '0, 1'b0, cap_a);
        wclk(2);
        frame(cmd_b, 16, 0, '0, 1'b0, cap_b);
        wclk(8);
        model_sel = cmd_b[13:11];
        checks++;
        assert (cap_a === exp_a) else begin
            errors++;
            $error("FAIL b2b_a miso obs=%h exp=%h", cap_a, exp_a);
        end
        checks++;
        assert (cap_b === exp_b) else begin
            errors++;
            $error("FAIL b2b_b miso obs=%h exp=%h", cap_b, exp_b);
        end
        checks++;
        assert ((n_vld - v0) === 2) else begin
            errors++;
            $error("FAIL b2b cmd_vld pulses obs=%0d exp=2", n_vld - v0);
        end
        checks++;
        assert (ch_sel === model_sel) else begin
            errors++;
            $error("FAIL b2b ch_sel obs=%0d exp=%0d", ch_sel, model_sel);
        end

        // Randomized frames: random data, commands, lengths and coincident ends.
        for (int f = 0; f < 25; f++) begin
            ch_data = {$urandom, $urandom, $urandom};
            nr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : 16;
            run("rand", mk_cmd(3'($urandom)), nr, 0, '0,
                (nr > 0) && ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a frame.
        run("pre_rst", mk_cmd(3'd6), 16, 0, '0, 1'b0);
        cmd_a = mk_cmd(3'd3);
        SS_n  = 1'b0;
        wclk(5);
        for (int i = 0; i < 7; i++) begin
            SCLK = 1'b0;
            MOSI = cmd_a[15-i];
            wclk(5);
            SCLK = 1'b1;
            wclk(5);
        end
        SCLK = 1'b0;
        wclk(2);
        rst_n = 1'b0;
        #1;
        model_sel = '0;
        checks++;
        assert (MISO === 1'b0) else begin
            errors++;
            $error("FAIL midrst miso obs=%b exp=0", MISO);
        end
        checks++;
        assert (ch_sel === model_sel) else begin
            errors++;
            $error("FAIL midrst ch_sel obs=%0d exp=%0d", ch_sel, model_sel);
        end
        SS_n = 1'b1;
        SCLK = 1'b1;
        MOSI = 1'b0;
        wclk(3);
        rst_n = 1'b1;
        wclk(4);
        run("after_rst", mk_cmd(3'd2), 16, 0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
